// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Shares a single-port instruction memory between the fetch stage (reads)
//   and the program loader (word writes). Loader writes wait in a small FIFO
//   that drains into idle fetch cycles. Fetch is stalled, and the FIFO drained,
//   when a queued write has been starved for STARVE_LIMIT fetch-won cycles or
//   when fetch targets a word that is still queued.
//
// Parameters
//   DEPTH         loader FIFO entries (power of two, >= 2)
//   STARVE_LIMIT  max consecutive fetch-won cycles while the FIFO is non-empty (>= 1)
//
// Ports
//   clock, reset_n        clock, asynchronous active-low reset
//   fetch_req/fetch_pc    fetch request and word-aligned absolute address
//   fetch_valid           fetch_data valid this cycle
//   fetch_stall           fetch_req refused this cycle; hold fetch_pc
//   fetch_data            pass-through of mem_data_out
//   ld_valid/ld_ready     loader write handshake
//   ld_addr/ld_data       loader write address (bits [1:0] dropped) and data
//   ld_count              number of queued entries
//   mem_pc                memory address (absolute, unmodified)
//   mem_read_write        1 = write cycle, 0 = read cycle
//   mem_data_in           write data to memory
//   mem_data_out          read data from memory
//
// Every output except the registered ld_count is a same-cycle function of the
// request inputs, so fetch sees zero-latency reads.

module imem_port_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     fetch_req,
    input  logic [31:0]              fetch_pc,
    output logic                     fetch_valid,
    output logic                     fetch_stall,
    output logic [31:0]              fetch_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [31:0]              ld_addr,
    input  logic [31:0]              ld_data,
    output logic [$clog2(DEPTH):0]   ld_count,
    output logic [31:0]              mem_pc,
    output logic                     mem_read_write,
    output logic [31:0]              mem_data_in,
    input  logic [31:0]              mem_data_out
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    // Queued loader write; addr keeps bits [1:0] forced to zero.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } ld_entry_t;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [CW-1:0]   drain_left;
    logic [CW-1:0]   drain_left_nxt;
    logic [SW-1:0]   starve_cnt;
    logic [SW-1:0]   starve_nxt;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_nxt;
    ld_entry_t       entries [DEPTH];

    logic            non_empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            hazard;
    logic            starved;
    logic            go_drain;
    logic            write_cycle;
    logic [31:0]     ld_addr_aligned;
    ld_entry_t       head;

    // FIFO status and handshake.
    assign non_empty       = (count != '0);
    assign full            = (count == CW'(DEPTH));
    assign ld_ready        = reset_n && !full;
    assign push            = ld_valid && ld_ready;
    assign ld_addr_aligned = ld_addr & 32'hFFFF_FFFC;
    assign head            = entries[rd_ptr];
    assign ld_count        = count;

    // Read-after-queued-write hazard: compares only registered entries, so a
    // same-cycle push is not seen until the next cycle.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr == {fetch_pc[31:2], 2'b00})) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && fetch_req;
    end

    // Arbitration: the drain decision is combinational so the first drain
    // write lands in the same cycle that triggers it.
    assign starved     = (starve_cnt == SW'(STARVE_LIMIT));
    assign go_drain    = (state == S_FETCH) && non_empty && (starved || hazard);
    assign write_cycle = non_empty && ((state == S_DRAIN) || !fetch_req || go_drain);
    assign pop         = write_cycle;

    // Memory port and fetch responses.
    assign mem_read_write = reset_n && write_cycle;
    assign mem_pc         = write_cycle ? head.addr : fetch_pc;
    assign mem_data_in    = write_cycle ? head.data : 32'h0;
    assign fetch_valid    = reset_n && fetch_req && !write_cycle;
    assign fetch_stall    = reset_n && fetch_req && write_cycle;
    assign fetch_data     = mem_data_out;

    // Next-state: drain mode and drain budget.
    always_comb begin
        state_nxt      = state;
        drain_left_nxt = drain_left;
        case (state)
            S_FETCH: begin
                if (go_drain) begin
                    // The pop in this cycle already counts toward the drain.
                    drain_left_nxt = CW'(count - CW'(1));
                    if (count != CW'(1)) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Only entries present at drain entry are drained, bounding the stall.
                if (!non_empty || (drain_left <= CW'(1))) begin
                    state_nxt      = S_FETCH;
                    drain_left_nxt = '0;
                end else begin
                    drain_left_nxt = CW'(drain_left - CW'(1));
                end
            end
            default: begin
                state_nxt      = S_FETCH;
                drain_left_nxt = '0;
            end
        endcase
    end

    // Starvation counter: counts fetch-won cycles while writes are waiting.
    always_comb begin
        starve_nxt = starve_cnt;
        if (write_cycle || !non_empty) begin
            starve_nxt = '0;
        end else if (fetch_req && !starved) begin
            starve_nxt = SW'(starve_cnt + SW'(1));
        end
    end

    // Occupancy and per-entry valid bits.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = CW'(count + CW'(1));
            2'b01:   count_nxt = CW'(count - CW'(1));
            default: count_nxt = count;
        endcase

        valid_nxt = valid;
        if (pop) begin
            valid_nxt[rd_ptr] = 1'b0;
        end
        if (push) begin
            valid_nxt[wr_ptr] = 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_FETCH;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            drain_left <= '0;
            starve_cnt <= '0;
            valid      <= '0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            drain_left <= drain_left_nxt;
            starve_cnt <= starve_nxt;
            valid      <= valid_nxt;
            if (push) begin
                wr_ptr <= PW'(wr_ptr + PW'(1));
            end
            if (pop) begin
                rd_ptr <= PW'(rd_ptr + PW'(1));
            end
        end
    end

    // Entry storage; contents are qualified by the valid bits, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            entries[wr_ptr] <= '{addr: ld_addr_aligned, data: ld_data};
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STARVE_LIMIT = 8;
    localparam int unsigned CW           = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          fetch_req;
    logic [31:0]   fetch_pc;
    logic          fetch_valid;
    logic          fetch_stall;
    logic [31:0]   fetch_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_data;
    logic [CW-1:0] ld_count;
    logic [31:0]   mem_pc;
    logic          mem_read_write;
    logic [31:0]   mem_data_in;
    logic [31:0]   mem_data_out;

    logic [31:0]   mem [256];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    imem_port_arbiter #(
        .DEPTH       (DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .fetch_req     (fetch_req),
        .fetch_pc      (fetch_pc),
        .fetch_valid   (fetch_valid),
        .fetch_stall   (fetch_stall),
        .fetch_data    (fetch_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .ld_count      (ld_count),
        .mem_pc        (mem_pc),
        .mem_read_write(mem_read_write),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out)
    );

    // Single-port memory model: async read, write committed at the clock edge.
    assign mem_data_out = mem[mem_pc[9:2]];
    always @(posedge clock) begin
        if (mem_read_write) mem[mem_pc[9:2]] <= mem_data_in;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; fetch_req = 1'b1; fetch_pc = 32'h0100_0000;
        ld_valid = 1'b1; ld_addr = 32'h0100_0040; ld_data = 32'h1111_1111;
        cyc(); cyc();
        tests_run++;
        if ({fetch_valid, fetch_stall, mem_read_write, ld_ready} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b exp=0000", {fetch_valid, fetch_stall, mem_read_write, ld_ready});
        end
        tests_run++;
        if (ld_count !== CW'(0)) begin
            tests_failed++; $display("FAIL reset_count got=%0d exp=0", ld_count);
        end
        ld_valid = 1'b0; reset_n = 1'b1;
        #1;
        tests_run++;
        if ({fetch_valid, fetch_stall, mem_read_write, ld_ready} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL reset_release got=%b exp=1001", {fetch_valid, fetch_stall, mem_read_write, ld_ready});
        end
        cyc();
    endtask

    task automatic test_fetch();
        fetch_req = 1'b1; ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fetch_pc = 32'h0100_0000 + 32'(k * 4);
            #1;
            tests_run++;
            if ({fetch_valid, fetch_stall, mem_read_write} !== 3'b100) begin
                tests_failed++; $display("FAIL fetch_flags[%0d] got=%b exp=100", k, {fetch_valid, fetch_stall, mem_read_write});
            end
            tests_run++;
            if (fetch_data !== 32'hA500_0000 + 32'(k)) begin
                tests_failed++; $display("FAIL fetch_data[%0d] got=%h exp=%h", k, fetch_data, 32'hA500_0000 + 32'(k));
            end
            cyc();
        end
    endtask

    task automatic test_idle_drain();
        fetch_req = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h0100_0010; ld_data = 32'hDEAD_BEEF;
        #1;
        tests_run++;
        if ({ld_ready, mem_read_write} !== 2'b10) begin
            tests_failed++; $display("FAIL idle_push0 got=%b exp=10", {ld_ready, mem_read_write});
        end
        cyc();
        ld_addr = 32'h0100_0017; ld_data = 32'h1234_5678;
        #1;
        tests_run++;
        if ({fetch_valid, fetch_stall, mem_read_write, mem_pc, mem_data_in, ld_count}
            !== {3'b001, 32'h0100_0010, 32'hDEAD_BEEF, CW'(1)}) begin
            tests_failed++;
            $display("FAIL idle_wr0 got mrw=%b pc=%h d=%h cnt=%0d exp mrw=1 pc=01000010 d=deadbeef cnt=1",
                     mem_read_write, mem_pc, mem_data_in, ld_count);
        end
        cyc();
        ld_valid = 1'b0;
        #1;
        tests_run++;
        if ({fetch_valid, fetch_stall, mem_read_write, mem_pc, mem_data_in, ld_count}
            !== {3'b001, 32'h0100_0014, 32'h1234_5678, CW'(1)}) begin
            tests_failed++;
            $display("FAIL idle_wr1 got mrw=%b pc=%h d=%h cnt=%0d exp mrw=1 pc=01000014 d=12345678 cnt=1",
                     mem_read_write, mem_pc, mem_data_in, ld_count);
        end
        cyc();
        fetch_req = 1'b1; fetch_pc = 32'h0100_0010;
        #1;
        tests_run++;
        if ({fetch_valid, mem_read_write, fetch_data, ld_count} !== {2'b10, 32'hDEAD_BEEF, CW'(0)}) begin
            tests_failed++;
            $display("FAIL idle_readback0 got v=%b mrw=%b d=%h cnt=%0d exp v=1 mrw=0 d=deadbeef cnt=0",
                     fetch_valid, mem_read_write, fetch_data, ld_count);
        end
        cyc();
        fetch_pc = 32'h0100_0014;
        #1;
        tests_run++;
        if (fetch_data !== 32'h1234_5678) begin
            tests_failed++; $display("FAIL idle_readback1 got=%h exp=12345678", fetch_data);
        end
        cyc();
    endtask

    task automatic test_starve();
        fetch_req = 1'b1; fetch_pc = 32'h0100_0000;
        ld_valid = 1'b1; ld_addr = 32'h0100_0030; ld_data = 32'hCAFE_F00D;
        #1;
        tests_run++;
        if ({fetch_valid, fetch_stall, mem_read_write} !== 3'b100) begin
            tests_failed++; $display("FAIL starve_push got=%b exp=100", {fetch_valid, fetch_stall, mem_read_write});
        end
        cyc();
        ld_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            tests_run++;
            if ({fetch_valid, fetch_stall, mem_read_write} !== 3'b100) begin
                tests_failed++; $display("FAIL starve_fetch[%0d] got=%b exp=100", k, {fetch_valid, fetch_stall, mem_read_write});
            end
            cyc();
        end
        #1;
        tests_run++;
        if ({fetch_valid, fetch_stall, mem_read_write, mem_pc} !== {3'b011, 32'h0100_0030}) begin
            tests_failed++;
            $display("FAIL starve_write got flags=%b pc=%h exp flags=011 pc=01000030",
                     {fetch_valid, fetch_stall, mem_read_write}, mem_pc);
        end
        cyc();
        #1;
        tests_run++;
        if ({fetch_valid, fetch_stall, mem_read_write, ld_count} !== {3'b100, CW'(0)}) begin
            tests_failed++;
            $display("FAIL starve_resume got flags=%b cnt=%0d exp flags=100 cnt=0",
                     {fetch_valid, fetch_stall, mem_read_write}, ld_count);
        end
        cyc();
        fetch_pc = 32'h0100_0030;
        #1;
        tests_run++;
        if (fetch_data !== 32'hCAFE_F00D) begin
            tests_failed++; $display("FAIL starve_readback got=%h exp=cafef00d", fetch_data);
        end
        cyc();
    endtask

    task automatic test_hazard();
        fetch_req = 1'b1; fetch_pc = 32'h0100_0000;
        ld_valid = 1'b1; ld_addr = 32'h0100_0020; ld_data = 32'hBEEF_0020;
        #1;
        tests_run++;
        if ({fetch_valid, fetch_stall} !== 2'b10) begin
            tests_failed++; $display("FAIL hazard_push got=%b exp=10", {fetch_valid, fetch_stall});
        end
        cyc();
        ld_valid = 1'b0; fetch_pc = 32'h0100_0020;
        #1;
        tests_run++;
        if ({fetch_valid, fetch_stall, mem_read_write, mem_pc} !== {3'b011, 32'h0100_0020}) begin
            tests_failed++;
            $display("FAIL hazard_stall got flags=%b pc=%h exp flags=011 pc=01000020",
                     {fetch_valid, fetch_stall, mem_read_write}, mem_pc);
        end
        cyc();
        #1;
        tests_run++;
        if ({fetch_valid, fetch_stall, mem_read_write, fetch_data} !== {3'b100, 32'hBEEF_0020}) begin
            tests_failed++;
            $display("FAIL hazard_read got flags=%b d=%h exp flags=100 d=beef0020",
                     {fetch_valid, fetch_stall, mem_read_write}, fetch_data);
        end
        cyc();
    endtask

    task automatic test_full_drain();
        fetch_req = 1'b1; fetch_pc = 32'h0100_0000;
        for (int k = 0; k < 4; k++) begin
            ld_valid = 1'b1; ld_addr = 32'h0100_0100 + 32'(k * 4); ld_data = 32'h5000_0000 + 32'(k);
            #1;
            tests_run++;
            if ({fetch_valid, fetch_stall, ld_ready} !== 3'b101) begin
                tests_failed++; $display("FAIL full_fill[%0d] got=%b exp=101", k, {fetch_valid, fetch_stall, ld_ready});
            end
            cyc();
        end
        ld_addr = 32'h0100_0200; ld_data = 32'h6000_0200;
        #1;
        tests_run++;
        if ({ld_ready, ld_count, fetch_valid} !== {1'b0, CW'(4), 1'b1}) begin
            tests_failed++;
            $display("FAIL full_ready got rdy=%b cnt=%0d v=%b exp rdy=0 cnt=4 v=1", ld_ready, ld_count, fetch_valid);
        end
        cyc();
        fetch_pc = 32'h0100_0100;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests_run++;
            if ({fetch_valid, fetch_stall, mem_read_write, mem_pc, mem_data_in}
                !== {3'b011, 32'h0100_0100 + 32'(k * 4), 32'h5000_0000 + 32'(k)}) begin
                tests_failed++;
                $display("FAIL full_drain[%0d] got flags=%b pc=%h d=%h exp flags=011 pc=%h d=%h", k,
                         {fetch_valid, fetch_stall, mem_read_write}, mem_pc, mem_data_in,
                         32'h0100_0100 + 32'(k * 4), 32'h5000_0000 + 32'(k));
            end
            tests_run++;
            if (ld_ready !== (k != 0)) begin
                tests_failed++; $display("FAIL full_drain_ready[%0d] got=%b exp=%b", k, ld_ready, k != 0);
            end
            cyc();
            if (k == 1) ld_valid = 1'b0;
        end
        #1;
        tests_run++;
        if ({fetch_valid, fetch_stall, mem_read_write, fetch_data, ld_count} !== {3'b100, 32'h5000_0000, CW'(1)}) begin
            tests_failed++;
            $display("FAIL full_resume got flags=%b d=%h cnt=%0d exp flags=100 d=50000000 cnt=1",
                     {fetch_valid, fetch_stall, mem_read_write}, fetch_data, ld_count);
        end
        cyc();
        fetch_req = 1'b0;
        #1;
        tests_run++;
        if ({mem_read_write, mem_pc, mem_data_in} !== {1'b1, 32'h0100_0200, 32'h6000_0200}) begin
            tests_failed++;
            $display("FAIL full_late_write got mrw=%b pc=%h d=%h exp mrw=1 pc=01000200 d=60000200",
                     mem_read_write, mem_pc, mem_data_in);
        end
        cyc();
        fetch_req = 1'b1; fetch_pc = 32'h0100_0200;
        #1;
        tests_run++;
        if ({fetch_valid, fetch_data, ld_count} !== {1'b1, 32'h6000_0200, CW'(0)}) begin
            tests_failed++;
            $display("FAIL full_late_read got v=%b d=%h cnt=%0d exp v=1 d=60000200 cnt=0", fetch_valid, fetch_data, ld_count);
        end
        cyc();
    endtask

    task automatic test_reset_mid_drain();
        fetch_req = 1'b1; fetch_pc = 32'h0100_0000;
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1; ld_addr = 32'h0100_0300 + 32'(k * 4); ld_data = 32'h7000_0000 + 32'(k);
            cyc();
        end
        ld_valid = 1'b0; fetch_pc = 32'h0100_0300;
        #1;
        tests_run++;
        if ({fetch_stall, mem_read_write, mem_pc} !== {2'b11, 32'h0100_0300}) begin
            tests_failed++; $display("FAIL rst_drain0 got s=%b mrw=%b pc=%h exp s=1 mrw=1 pc=01000300",
                                     fetch_stall, mem_read_write, mem_pc);
        end
        cyc();
        #1;
        tests_run++;
        if ({fetch_stall, mem_read_write, mem_pc, ld_count} !== {2'b11, 32'h0100_0304, CW'(2)}) begin
            tests_failed++; $display("FAIL rst_drain1 got s=%b mrw=%b pc=%h cnt=%0d exp s=1 mrw=1 pc=01000304 cnt=2",
                                     fetch_stall, mem_read_write, mem_pc, ld_count);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({fetch_valid, fetch_stall, mem_read_write, ld_ready, ld_count} !== {4'b0000, CW'(0)}) begin
            tests_failed++; $display("FAIL rst_assert got flags=%b cnt=%0d exp flags=0000 cnt=0",
                                     {fetch_valid, fetch_stall, mem_read_write, ld_ready}, ld_count);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            tests_run++;
            if (mem_read_write !== 1'b0) begin
                tests_failed++; $display("FAIL rst_hold[%0d] got mrw=%b exp=0", k, mem_read_write);
            end
        end
        reset_n = 1'b1; fetch_pc = 32'h0100_0304;
        #1;
        tests_run++;
        if ({fetch_valid, fetch_stall, mem_read_write, ld_ready, ld_count, fetch_data}
            !== {4'b1001, CW'(0), 32'hA500_00C1}) begin
            tests_failed++; $display("FAIL rst_release got flags=%b cnt=%0d d=%h exp flags=1001 cnt=0 d=a50000c1",
                                     {fetch_valid, fetch_stall, mem_read_write, ld_ready}, ld_count, fetch_data);
        end
        cyc();
        fetch_pc = 32'h0100_0300;
        #1;
        tests_run++;
        if ({fetch_valid, fetch_data} !== {1'b1, 32'h7000_0000}) begin
            tests_failed++; $display("FAIL rst_committed got v=%b d=%h exp v=1 d=70000000", fetch_valid, fetch_data);
        end
        cyc();
        fetch_pc = 32'h0100_0308;
        #1;
        tests_run++;
        if ({fetch_valid, fetch_stall, fetch_data} !== {2'b10, 32'hA500_00C2}) begin
            tests_failed++; $display("FAIL rst_discarded got v=%b s=%b d=%h exp v=1 s=0 d=a50000c2",
                                     fetch_valid, fetch_stall, fetch_data);
        end
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);
        test_reset();
        test_fetch();
        test_idle_drain();
        test_starve();
        test_hazard();
        test_full_drain();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
